pu_msp430_wb_sr: RTL and testbench
==================================

Name: pu_msp430_wb_sr

Overview:
- Writeback stage directly downstream of the MSP430 ALU.
- Accepts one ALU result per execution beat and routes it to the register file or to the data-memory write port.
- Owns the R2 status register and feeds the registered {V,N,Z,C} back to the ALU `status` input.
- Stalls the execution unit with a ready handshake while a memory write is outstanding.

Parameters:
- SR_RST, 16'h0000, SR value loaded on reset.

Ports:
- mclk  in  1  core clock
- puc_rst  in  1  synchronous active-high reset
- wb_valid  in  1  ALU result valid this cycle (exec beat)
- wb_ready  out  1  stage can accept a result
- alu_out  in  16  ALU result
- alu_stat  in  4  ALU flags {V,N,Z,C}
- alu_stat_wr  in  4  per-flag write enables {V,N,Z,C}
- inst_bw  in  1  byte-width operation
- dst_mem  in  1  1 = destination is memory, 0 = register
- dst_reg  in  4  destination register number (when dst_mem=0)
- dst_addr  in  16  destination byte address (when dst_mem=1)
- irq_ack  in  1  interrupt accepted; clear GIE/CPUOFF/OSCOFF/SCG1
- reti_sr  in  1  load SR from alu_out (RETI pop)
- reg_we  out  1  register-file write strobe
- reg_addr  out  4  register-file write address
- reg_data  out  16  register-file write data
- mem_wr  out  1  memory write request, held until ack
- mem_be  out  2  memory byte enables
- mem_addr  out  16  memory write address
- mem_data  out  16  memory write data
- mem_ack  in  1  memory write accepted
- status  out  4  SR[8],SR[2],SR[1],SR[0] = {V,N,Z,C} to ALU
- gie  out  1  SR[3]
- cpuoff  out  1  SR[4]
- oscoff  out  1  SR[5]
- scg1  out  1  SR[7]

Behaviour:
- Clocking: all state on rising mclk.
- puc_rst: synchronous; overrides every other input in the same cycle.
- Reset values: SR=SR_RST, FSM=IDLE, wb_ready=1, reg_we=0, mem_wr=0, all address/data/be outputs 0.
- Accept rule: a result is accepted when wb_valid & wb_ready.
- FSM states: IDLE, MEM_WAIT.
- IDLE, accept with dst_mem=0:
  - next cycle reg_we=1 for exactly one cycle, with reg_addr=dst_reg.
  - reg_data=alu_out, or {8'h00,alu_out[7:0]} if inst_bw.
  - stay in IDLE; back-to-back accepts are allowed every cycle.
  - dst_reg=3 (CG2): write discarded, reg_we stays 0.
  - dst_reg=2: handled by the SR logic below, not by reg_we.
- IDLE, accept with dst_mem=1:
  - next cycle mem_wr=1; go to MEM_WAIT; wb_ready=0 from that cycle.
  - mem_addr/mem_data captured at accept.
  - inst_bw=1: mem_data={alu_out[7:0],alu_out[7:0]}, mem_be=dst_addr[0]?2'b10:2'b01.
  - inst_bw=0: mem_data=alu_out, mem_be=2'b11, mem_addr[0] forced to 0.
- MEM_WAIT:
  - mem_wr and all mem_* outputs held stable until a cycle where mem_ack=1.
  - the following cycle: mem_wr=0, wb_ready=1, state=IDLE.
  - mem_ack in the same cycle mem_wr first rises counts as that request's ack.
  - mem_ack in IDLE is ignored.
- SR update, applied in the cycle after accept, priority high to low:
  1. puc_rst.
  2. irq_ack clears GIE, CPUOFF, OSCOFF, SCG1. Other bits then follow the rules below.
  3. reti_sr, or register write with dst_reg=2: SR = alu_out & 16'h01FF. Byte form: SR[7:0]=alu_out[7:0] and SR[8] cleared.
  4. Otherwise each flag with alu_stat_wr[i]=1 takes alu_stat[i].
  - A full SR write (rule 3) beats flag writes in the same beat.
- status/gie/cpuoff/oscoff/scg1 are direct register outputs. A flag written by beat N is visible to the ALU on beat N+1.
- SR bits 15:9 always read 0.
- Reset during MEM_WAIT: request dropped, mem_wr=0 the next cycle, FSM=IDLE.

Optional Feature:
- Macro: PU_MSP430_SCG_EN.
- Defined: SR[6] (SCG0) and SR[7] (SCG1) are writable via rule 3, and scg1 reflects SR[7].
- Undefined: SR[7:6] are forced to 0 on every write, and scg1 is tied to 0.

Test Plan:
- Reset then idle: status=0, wb_ready=1, reg_we=0, mem_wr=0 for 5 cycles.
- Register write: accept alu_out=16'h1234, dst_reg=5, inst_bw=0 -> next cycle reg_we=1, reg_addr=5, reg_data=16'h1234; cycle after, reg_we=0.
- Flag update: alu_stat=4'b0110, alu_stat_wr=4'b1111 -> status=4'b0110 next cycle. Then alu_stat_wr=4'b0001 with alu_stat=4'b1001 -> status=4'b0111.
- Byte memory write: alu_out=16'hABCD, inst_bw=1, dst_addr=16'h0201; mem_ack held low 3 cycles -> mem_wr high 4 cycles, mem_data=16'hCDCD, mem_be=2'b10, wb_ready=0 throughout; wb_ready=1 the cycle after ack.
- Simultaneous events: dst_reg=2, alu_out=16'h00F8, alu_stat_wr=4'b1111, irq_ack=1 -> SR=16'h0040 with PU_MSP430_SCG_EN defined, 16'h0000 without.
- Reset in MEM_WAIT: assert puc_rst while mem_wr=1 -> next cycle mem_wr=0, wb_ready=1, SR=SR_RST.

Source files
------------

// File: rtl/pu_msp430_wb_sr.sv
// rtl/pu_msp430_wb_sr.sv - MSP430 writeback stage: register/memory routing and R2 status register.
// Optional SCG0/SCG1 write support is enabled with `define PU_MSP430_SCG_EN.
module pu_msp430_wb_sr #(
    parameter logic [15:0] SR_RST = 16'h0000
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_stat,
    input  logic [3:0]  alu_stat_wr,
    input  logic        inst_bw,
    input  logic        dst_mem,
    input  logic [3:0]  dst_reg,
    input  logic [15:0] dst_addr,
    input  logic        irq_ack,
    input  logic        reti_sr,
    output logic        reg_we,
    output logic [3:0]  reg_addr,
    output logic [15:0] reg_data,
    output logic        mem_wr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic [3:0]  status,
    output logic        gie,
    output logic        cpuoff,
    output logic        oscoff,
    output logic        scg1
);

    typedef enum logic {IDLE, MEM_WAIT} state_t;

`ifdef PU_MSP430_SCG_EN
    localparam logic [8:0] SR_WMASK = 9'h1FF;
`else
    localparam logic [8:0] SR_WMASK = 9'h13F;
`endif

    state_t      state_q, state_d;
    logic        wb_ready_q, wb_ready_d;
    logic        reg_we_q, reg_we_d;
    logic [3:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_data_q, reg_data_d;
    logic        mem_wr_q, mem_wr_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_data_q, mem_data_d;
    logic [8:0]  sr_q, sr_d;

    logic accept;
    logic sr_full_wr;
    logic reg_wr;

    always_comb begin
        state_d    = state_q;
        wb_ready_d = wb_ready_q;
        reg_we_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        mem_wr_d   = mem_wr_q;
        mem_be_d   = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        sr_d       = sr_q;

        accept     = wb_valid & wb_ready_q;
        sr_full_wr = accept & (reti_sr | (~dst_mem & (dst_reg == 4'd2)));
        reg_wr     = accept & ~dst_mem & (dst_reg != 4'd2) & (dst_reg != 4'd3);

        case (state_q)
            IDLE: begin
                if (accept && dst_mem) begin
                    state_d    = MEM_WAIT;
                    mem_wr_d   = 1'b1;
                    wb_ready_d = 1'b0;
                    if (inst_bw) begin
                        mem_addr_d = dst_addr;
                        mem_data_d = {alu_out[7:0], alu_out[7:0]};
                        mem_be_d   = dst_addr[0] ? 2'b10 : 2'b01;
                    end else begin
                        mem_addr_d = {dst_addr[15:1], 1'b0};
                        mem_data_d = alu_out;
                        mem_be_d   = 2'b11;
                    end
                end
            end
            MEM_WAIT: begin
                // mem_* stay frozen until the ack, so the memory side sees a stable request
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_wr_d   = 1'b0;
                    wb_ready_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                mem_wr_d   = 1'b0;
                wb_ready_d = 1'b1;
            end
        endcase

        if (reg_wr) begin
            reg_we_d   = 1'b1;
            reg_addr_d = dst_reg;
            reg_data_d = inst_bw ? {8'h00, alu_out[7:0]} : alu_out;
        end

        if (sr_full_wr) begin
            sr_d = (inst_bw ? {1'b0, alu_out[7:0]} : alu_out[8:0]) & SR_WMASK;
        end else if (accept) begin
            if (alu_stat_wr[0]) sr_d[0] = alu_stat[0];
            if (alu_stat_wr[1]) sr_d[1] = alu_stat[1];
            if (alu_stat_wr[2]) sr_d[2] = alu_stat[2];
            if (alu_stat_wr[3]) sr_d[8] = alu_stat[3];
        end

        // Interrupt entry wakes the CPU regardless of what the beat wrote into SR
        if (irq_ack) begin
            sr_d[3] = 1'b0;
            sr_d[4] = 1'b0;
            sr_d[5] = 1'b0;
            sr_d[7] = 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q    <= IDLE;
            wb_ready_q <= 1'b1;
            reg_we_q   <= 1'b0;
            reg_addr_q <= 4'h0;
            reg_data_q <= 16'h0000;
            mem_wr_q   <= 1'b0;
            mem_be_q   <= 2'b00;
            mem_addr_q <= 16'h0000;
            mem_data_q <= 16'h0000;
            sr_q       <= SR_RST[8:0];
        end else begin
            state_q    <= state_d;
            wb_ready_q <= wb_ready_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            mem_wr_q   <= mem_wr_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            sr_q       <= sr_d;
        end
    end

    assign wb_ready = wb_ready_q;
    assign reg_we   = reg_we_q;
    assign reg_addr = reg_addr_q;
    assign reg_data = reg_data_q;
    assign mem_wr   = mem_wr_q;
    assign mem_be   = mem_be_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign status   = {sr_q[8], sr_q[2], sr_q[1], sr_q[0]};
    assign gie      = sr_q[3];
    assign cpuoff   = sr_q[4];
    assign oscoff   = sr_q[5];
`ifdef PU_MSP430_SCG_EN
    assign scg1     = sr_q[7];
`else
    assign scg1     = 1'b0;
`endif

endmodule

// File: tb/tb_pu_msp430_wb_sr.sv
// tb/tb_pu_msp430_wb_sr.sv - scoreboard bench for pu_msp430_wb_sr with a behavioural SR/writeback model.
module tb_pu_msp430_wb_sr;

    localparam logic [15:0] SR_RST = 16'h0000;
`ifdef PU_MSP430_SCG_EN
    localparam bit SCG = 1'b1;
`else
    localparam bit SCG = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [15:0] alu_out = 16'h0;
    logic [3:0]  alu_stat = 4'h0;
    logic [3:0]  alu_stat_wr = 4'h0;
    logic        inst_bw = 1'b0;
    logic        dst_mem = 1'b0;
    logic [3:0]  dst_reg = 4'h0;
    logic [15:0] dst_addr = 16'h0;
    logic        irq_ack = 1'b0;
    logic        reti_sr = 1'b0;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [15:0] reg_data;
    logic        mem_wr;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ack = 1'b0;
    logic [3:0]  status;
    logic        gie, cpuoff, oscoff, scg1;

    pu_msp430_wb_sr #(.SR_RST(SR_RST)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .alu_out(alu_out), .alu_stat(alu_stat), .alu_stat_wr(alu_stat_wr),
        .inst_bw(inst_bw), .dst_mem(dst_mem), .dst_reg(dst_reg), .dst_addr(dst_addr),
        .irq_ack(irq_ack), .reti_sr(reti_sr), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_data(reg_data), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack), .status(status), .gie(gie),
        .cpuoff(cpuoff), .oscoff(oscoff), .scg1(scg1)
    );

    always #5 mclk = ~mclk;

    typedef struct { logic [3:0] a; logic [15:0] d; } reg_t;
    typedef struct { logic [15:0] a; logic [15:0] d; logic [1:0] be; } mem_t;

    reg_t        reg_q[$];
    mem_t        mem_q[$];
    logic [15:0] m_sr = SR_RST;
    bit          m_busy = 1'b0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: SR as a plain 16-bit word, writes as queued transactions
    always @(posedge mclk) begin
        if (puc_rst) begin
            m_sr = SR_RST;
            m_busy = 1'b0;
            reg_q.delete();
            mem_q.delete();
        end else begin
            bit     acc;
            mem_t   m;
            reg_t   r;
            acc = wb_valid && !m_busy;
            if (m_busy && mem_ack) begin
                m_busy = 1'b0;
                if (mem_q.size() > 0) void'(mem_q.pop_front());
            end
            if (acc) begin
                if (reti_sr || (!dst_mem && dst_reg == 4'd2)) begin
                    m_sr = inst_bw ? {8'h00, alu_out[7:0]} : (alu_out & 16'h01FF);
                    if (!SCG) m_sr = m_sr & ~16'h00C0;
                end else begin
                    if (alu_stat_wr[0]) m_sr[0] = alu_stat[0];
                    if (alu_stat_wr[1]) m_sr[1] = alu_stat[1];
                    if (alu_stat_wr[2]) m_sr[2] = alu_stat[2];
                    if (alu_stat_wr[3]) m_sr[8] = alu_stat[3];
                end
                if (dst_mem) begin
                    m.be = inst_bw ? (dst_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                    m.a  = inst_bw ? dst_addr : (dst_addr & 16'hFFFE);
                    m.d  = inst_bw ? {alu_out[7:0], alu_out[7:0]} : alu_out;
                    mem_q.push_back(m);
                    m_busy = 1'b1;
                end else if (dst_reg != 4'd2 && dst_reg != 4'd3) begin
                    r.a = dst_reg;
                    r.d = inst_bw ? {8'h00, alu_out[7:0]} : alu_out;
                    reg_q.push_back(r);
                end
            end
            if (irq_ack) m_sr = m_sr & ~16'h00B8;
        end
    end

    always @(negedge mclk) begin
        if (mon_en) begin
            reg_t r;
            chk("status", {28'h0, status}, {28'h0, m_sr[8], m_sr[2], m_sr[1], m_sr[0]});
            chk("ctrl_bits", {28'h0, gie, cpuoff, oscoff, scg1},
                {28'h0, m_sr[3], m_sr[4], m_sr[5], (SCG ? m_sr[7] : 1'b0)});
            chk("wb_ready", {31'h0, wb_ready}, {31'h0, !m_busy});
            if (reg_we) begin
                if (reg_q.size() == 0) chk("reg_we_unexpected", 32'd1, 32'd0);
                else begin
                    r = reg_q.pop_front();
                    chk("reg_write", {12'h0, reg_addr, reg_data}, {12'h0, r.a, r.d});
                end
            end else if (reg_q.size() != 0) begin
                chk("reg_we_missing", 32'd0, 32'd1);
                reg_q.delete();
            end
            if (mem_wr) begin
                if (mem_q.size() == 0) chk("mem_wr_unexpected", 32'd1, 32'd0);
                else chk("mem_req", {mem_be, mem_addr[13:0], mem_data},
                         {mem_q[0].be, mem_q[0].a[13:0], mem_q[0].d});
            end else begin
                chk("mem_wr_missing", {31'h0, mem_q.size() != 0}, 32'd0);
            end
        end
    end

    task automatic beat(input logic v, input logic [15:0] alu, input logic [3:0] st,
                        input logic [3:0] stw, input logic bw, input logic dm,
                        input logic [3:0] dr, input logic [15:0] da, input logic irq,
                        input logic reti, input logic ack);
        wb_valid = v; alu_out = alu; alu_stat = st; alu_stat_wr = stw; inst_bw = bw;
        dst_mem = dm; dst_reg = dr; dst_addr = da; irq_ack = irq; reti_sr = reti; mem_ack = ack;
        @(negedge mclk);
    endtask

    task automatic idle(input logic ack);
        beat(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, ack);
    endtask

    initial begin
        @(negedge mclk);
        @(negedge mclk);
        puc_rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_idle", {28'h0, status[3:1], (status[0] | reg_we | mem_wr | ~wb_ready)}, 32'h0);
            idle(1'b0);
        end

        beat(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0, 1'b0, 4'd5, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("dir_reg", {11'h0, reg_we, reg_addr, reg_data}, {11'h0, 1'b1, 4'd5, 16'h1234});
        idle(1'b0);
        chk("dir_reg_pulse", {31'h0, reg_we}, 32'h0);

        beat(1'b1, 16'h0000, 4'b0110, 4'b1111, 1'b0, 1'b0, 4'd3, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("dir_flags1", {28'h0, status}, 32'b0110);
        beat(1'b1, 16'h0000, 4'b1001, 4'b0001, 1'b0, 1'b0, 4'd3, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("dir_flags2", {28'h0, status}, 32'b0111);

        beat(1'b1, 16'hABCD, 4'h0, 4'h0, 1'b1, 1'b1, 4'd0, 16'h0201, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("dir_bmem", {mem_wr, wb_ready, mem_be, mem_addr[11:0], mem_data},
                {1'b1, 1'b0, 2'b10, 12'h201, 16'hCDCD});
            idle(i == 3);
        end
        chk("dir_bmem_done", {30'h0, mem_wr, wb_ready}, 32'b01);

        beat(1'b1, 16'h00F8, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'd2, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("dir_simul", {24'h0, status, gie, cpuoff, oscoff, scg1}, 32'h0);

        beat(1'b1, 16'h5555, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'd0, 16'h1003, 1'b0, 1'b0, 1'b0);
        chk("dir_wmem", {mem_wr, status, mem_be, mem_addr, mem_data},
            {1'b1, 4'b1111, 2'b11, 16'h1002, 16'h5555});
        puc_rst = 1'b1;
        idle(1'b0);
        puc_rst = 1'b0;
        chk("dir_rst_memwait", {26'h0, mem_wr, wb_ready, status}, {26'h0, 1'b0, 1'b1, SR_RST[8], SR_RST[2:0]});

        for (int i = 0; i < 800; i++) begin
            logic       v, rdy, irq, reti, ack, dm;
            logic [3:0] dr;
            rdy  = wb_ready;
            v    = ($urandom_range(0, 2) != 0);
            irq  = v && rdy && ($urandom_range(0, 9) == 0);
            reti = v && rdy && ($urandom_range(0, 9) == 0);
            dm   = ($urandom_range(0, 3) == 0);
            dr   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 3)) : 4'($urandom_range(0, 15));
            ack  = ($urandom_range(0, 2) == 0);
            puc_rst = ($urandom_range(0, 79) == 0);
            beat(v, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), dm, dr,
                 16'($urandom), irq, reti, ack);
        end
        puc_rst = 1'b0;
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
